// File: rtl/adc_spi_responder.sv
// AD9653-style SPI register responder: oversampled SCLK/CSB/SDI, byte-wide
// register file, 16-bit instruction + data-byte protocol, write notification.
module adc_spi_responder #(
  parameter int unsigned aw       = 4,
  parameter int unsigned sync_len = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          csb,
  input  logic          sdi,
  output logic          sdo,
  output logic          sdo_oe,
  output logic          wr_stb,
  output logic [aw-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [aw-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned AL    = 13;
  localparam int unsigned DEPTH = 1 << aw;

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  logic [sync_len-1:0] sclk_sync, csb_sync, sdi_sync;
  logic                sclk_d, csb_d;
  logic                sclk_s, csb_s, sdi_s;
  logic                sclk_rise, sclk_fall, csb_fall;
  logic                addr_in_range;

  state_t              state;
  logic [3:0]          bit_cnt;
  logic [1:0]          byte_cnt;
  logic [1:0]          byte_w;
  logic                rnw;
  logic [AL-1:0]       addr;
  logic [14:0]         instr_sh;
  logic [6:0]          wr_sh;
  logic [7:0]          rd_sh;
  logic [7:0]          mem [DEPTH];

  assign sclk_s = sclk_sync[sync_len-1];
  assign csb_s  = csb_sync[sync_len-1];
  assign sdi_s  = sdi_sync[sync_len-1];

  // SCLK edges count only while the previous CSB sample was low, so an edge
  // arriving together with CSB rising is still honoured before the abort.
  assign sclk_rise     = sclk_s & ~sclk_d & ~csb_d;
  assign sclk_fall     = ~sclk_s & sclk_d & ~csb_d;
  assign csb_fall      = ~csb_s & csb_d;
  assign addr_in_range = (addr[AL-1:aw] == '0);

  // Register-file byte at a 13-bit SPI address; out-of-range reads as zero.
  function automatic logic [7:0] rf_byte(input logic [AL-1:0] a);
    if (a[AL-1:aw] == '0) return mem[a[aw-1:0]];
    return 8'h00;
  endfunction

  // Input synchronizers and previous-sample registers for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      csb_sync  <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      csb_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[sync_len-2:0], sclk};
      csb_sync  <= {csb_sync[sync_len-2:0], csb};
      sdi_sync  <= {sdi_sync[sync_len-2:0], sdi};
      sclk_d    <= sclk_s;
      csb_d     <= csb_s;
    end
  end

  // Protocol FSM, shift registers, register-file writes and SDO drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      byte_w   <= '0;
      rnw      <= 1'b0;
      addr     <= '0;
      instr_sh <= '0;
      wr_sh    <= '0;
      rd_sh    <= '0;
      sdo      <= 1'b0;
      sdo_oe   <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (csb_fall) begin
            state   <= INSTR;
            bit_cnt <= '0;
          end
        end
        INSTR: begin
          if (sclk_rise) begin
            instr_sh <= {instr_sh[13:0], sdi_s};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state    <= DATA;
              rnw      <= instr_sh[14];
              byte_w   <= instr_sh[13:12];
              addr     <= {instr_sh[11:0], sdi_s};
              byte_cnt <= '0;
              bit_cnt  <= '0;
              rd_sh    <= rf_byte({instr_sh[11:0], sdi_s});
            end
          end
        end
        DATA: begin
          if (sclk_fall && rnw) begin
            sdo    <= rd_sh[7];
            rd_sh  <= {rd_sh[6:0], 1'b0};
            sdo_oe <= 1'b1;
          end
          if (sclk_rise) begin
            wr_sh   <= {wr_sh[5:0], sdi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              addr     <= addr - 13'd1;
              byte_cnt <= byte_cnt + 2'd1;
              if (!rnw && addr_in_range) begin
                mem[addr[aw-1:0]] <= {wr_sh, sdi_s};
                wr_stb            <= 1'b1;
                wr_addr           <= addr[aw-1:0];
                wr_data           <= {wr_sh, sdi_s};
              end
              if (rnw) rd_sh <= rf_byte(addr - 13'd1);
              if (byte_w != 2'd3 && byte_cnt == byte_w) begin
                state  <= DONE;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
              end
            end
          end
        end
        DONE: begin
        end
      endcase
      if (csb_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sdo     <= 1'b0;
        sdo_oe  <= 1'b0;
      end
    end
  end

  // Local read port; a same-cycle SPI write to the address returns the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: SPI master driver, reference register model,
// and scoreboard monitors for write strobes and serial read bytes.
module tb_adc_spi_responder;

  localparam int unsigned HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       csb = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, sdo_oe, wr_stb;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [16];
  logic [7:0]  tx_buf [8];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  logic [7:0] rx_sh = 8'h00;
  int         rx_n = 0;

  always #5 clk = ~clk;

  adc_spi_responder #(.aw(4), .sync_len(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclk    (sclk),
    .csb     (csb),
    .sdi     (sdi),
    .sdo     (sdo),
    .sdo_oe  (sdo_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    wait_clks(HALF);
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  // Reference: byte i of a transaction targets (start - i) mod 8192.
  task automatic model_txn(input logic [15:0] ins, input int nfull);
    int a;
    for (int i = 0; i < nfull; i++) begin
      a = (int'(ins[12:0]) - i + 8192) % 8192;
      if (ins[15]) begin
        exp_rd.push_back(a < 16 ? model_mem[a] : 8'h00);
      end else if (a < 16) begin
        model_mem[a] = tx_buf[i];
        exp_wr.push_back({4'(a), tx_buf[i]});
      end
    end
  endtask

  task automatic spi_txn(input logic [15:0] ins, input int nbits, input int extra);
    csb = 1'b0;
    wait_clks(HALF);
    for (int i = 15; i >= 0; i--) send_bit(ins[i]);
    for (int j = 0; j < nbits; j++) send_bit(tx_buf[j/8][7-(j%8)]);
    for (int e = 0; e < extra; e++) begin
      send_bit(1'b1);
      chk("sdo_oe_in_done", 32'(sdo_oe), 32'd0);
    end
    wait_clks(HALF);
    csb = 1'b1;
    wait_clks(3*HALF);
    chk("sdo_oe_after_csb", 32'(sdo_oe), 32'd0);
  endtask

  task automatic check_rf();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      wait_clks(2);
      chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(model_mem[a]));
    end
  endtask

  // Write monitor: every wr_stb must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_stb_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[11:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  // Read monitor: master samples sdo on SCLK rise while the responder drives.
  always @(posedge sclk or posedge csb) begin
    if (csb) begin
      rx_n = 0;
    end else if (sdo_oe) begin
      rx_sh = {rx_sh[6:0], sdo};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sdo_byte_unexpected: got 0x%0h expected no read byte", rx_sh);
        end else begin
          chk("sdo_byte", 32'(rx_sh), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ins;
    foreach (model_mem[k]) model_mem[k] = 8'h00;

    // Reset values
    wait_clks(4);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_sdo_oe", 32'(sdo_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    wait_clks(10);
    check_rf();

    // Single-byte write
    tx_buf[0] = 8'hA5;
    model_txn(16'h0003, 1);
    spi_txn(16'h0003, 8, 0);
    rd_addr = 4'd3;
    wait_clks(2);
    chk("rd_reg3", 32'(rd_data), 32'hA5);

    // Streaming write of three bytes
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    model_txn(16'h6005, 3);
    spi_txn(16'h6005, 24, 0);
    check_rf();

    // Two-byte read, then SCLK activity in DONE
    model_txn(16'hA005, 2);
    spi_txn(16'hA005, 16, 4);

    // Aborted write after 5 data bits
    tx_buf[0] = 8'h7E;
    model_txn(16'h0000, 0);
    spi_txn(16'h0000, 5, 0);
    check_rf();

    // Streaming write wrapping below address 0
    tx_buf[0] = 8'hC1; tx_buf[1] = 8'hC0; tx_buf[2] = 8'hFF;
    model_txn(16'h6001, 3);
    spi_txn(16'h6001, 24, 0);
    check_rf();
    model_txn(16'h9FFF, 1);
    spi_txn(16'h9FFF, 8, 0);

    // Non-zero write outputs before the reset test
    tx_buf[0] = 8'h5A;
    model_txn(16'h000F, 1);
    spi_txn(16'h000F, 8, 0);
    rd_addr = 4'd5;
    wait_clks(2);
    chk("rd_pre_reset", 32'(rd_data), 32'(model_mem[5]));

    // Reset during instruction bit 8
    ins = 16'h0002;
    csb = 1'b0;
    wait_clks(HALF);
    for (int i = 15; i > 8; i--) send_bit(ins[i]);
    sdi = ins[8];
    wait_clks(HALF);
    sclk = 1'b1;
    wait_clks(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sdo", 32'(sdo), 32'd0);
    chk("mid_rst_sdo_oe", 32'(sdo_oe), 32'd0);
    chk("mid_rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    foreach (model_mem[k]) model_mem[k] = 8'h00;
    wait_clks(3);
    sclk = 1'b0;
    csb = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(4*HALF);
    check_rf();
    tx_buf[0] = 8'h3C;
    model_txn(16'h0002, 1);
    spi_txn(16'h0002, 8, 0);
    check_rf();

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      int w, a, nb;
      logic r;
      r  = 1'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 8190 : int'($urandom_range(0, 23));
      nb = (w == 3) ? int'($urandom_range(1, 5)) : w + 1;
      ins = {r, 2'(w), 13'(a)};
      for (int b = 0; b < nb; b++) tx_buf[b] = 8'($urandom);
      model_txn(ins, nb);
      spi_txn(ins, nb*8, 0);
      if (t % 4 == 3) check_rf();
    end

    wait_clks(20);
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates the AD9653-style register interface of the digitizer's ADC chips (U2/U3) as driven by the llspi master. It lets the llspi command path be exercised in simulation and in loopback builds without the physical board. SCLK, CSB and SDI are oversampled in a single system clock domain. A small byte-wide register file is written and read through the standard 16-bit instruction + data-byte protocol, and each completed write is reported to local logic.

## Interface
Parameters:
- aw, 4: register-file address width; the file holds 2^aw bytes at SPI addresses 0 .. 2^aw-1.
- sync_len, 2: synchronizer depth for sclk/csb/sdi.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master, asynchronous to clk.
- csb  in  1  chip select from the master, active low.
- sdi  in  1  serial data from the master.
- sdo  out  1  serial read data.
- sdo_oe  out  1  high while the responder drives read data; this is the 3-wire SDIO direction control.
- wr_stb  out  1  one-cycle pulse on each completed register write.
- wr_addr  out  aw  address of that write.
- wr_data  out  8  data of that write.
- rd_addr  in  aw  local read address.
- rd_data  out  8  register-file contents at rd_addr, registered with one-cycle latency.

## Operation
- Input conditioning: sclk, csb and sdi each pass through a sync_len-stage synchronizer. The block detects SCLK rising and falling edges from the synchronized samples and acts on an edge only while synchronized csb is low.
- Instruction word: 16 bits, MSB first, sampled on SCLK rising edges.
  - Bit 15 is R/W: 1 = read.
  - Bits 14:13 are W, the byte count: 0, 1 and 2 mean 1, 2 and 3 bytes; 3 means streaming until CSB rises.
  - Bits 12:0 are the 13-bit starting address.
- Data phase: bytes are MSB first. After each byte the address decrements by 1, modulo 2^13, so 0x0000 is followed by 0x1FFF.
- Write:
  - On the 8th rising edge of a byte, if address[12:aw] == 0, the byte is stored to reg[address[aw-1:0]] and wr_stb fires.
  - Writes to out-of-range addresses are discarded and wr_stb does not fire.
- Read:
  - The byte is loaded from the register file; an out-of-range address returns 0x00.
  - The MSB is driven after the SCLK falling edge that follows instruction bit 0. The remaining bits follow on successive falling edges.
  - sdo_oe is high from that first drive until the read ends.
- State machine:
  - IDLE to INSTR on csb falling.
  - INSTR to DATA after 16 bits.
  - DATA to DONE when the byte count is exhausted; with W=3 the block stays in DATA.
  - DONE ignores all SCLK activity.
  - Any state returns to IDLE on csb high.
- Abort: csb high mid-byte discards the partial byte, with no write and no wr_stb. sdo_oe drops, the bit counter clears, and the block returns to IDLE.
- The register file is written only from SPI. rd_data is an independent read port; when the local read and an SPI write hit the same address in the same cycle, rd_data returns the old value.

## Timing
- Reset values: state IDLE, sdo=0, sdo_oe=0, wr_stb=0, wr_addr=0, wr_data=0, rd_data=0, every register byte 0x00.
- rst_n asserted mid-transaction forces these values immediately; after release the block waits in IDLE for the next csb falling edge.
- Edge detection latency: sync_len+1 clk cycles from the pin transition.
- SCLK high and low phases must each last at least sync_len+2 clk cycles. Faster SCLK is unsupported and its behaviour is undefined.
- sdo and sdo_oe change 1 clk cycle after the internal falling-edge detect. Worst case is sync_len+2 cycles after the pin edge.
- wr_stb asserts 1 cycle after the internal detect of the 8th rising edge. The register file, wr_addr and wr_data update in that same cycle.
- After csb rises, sdo_oe is low within sync_len+2 cycles.
- A CSB rising edge coincident with the 8th SCLK rising edge of a byte: the write is completed. The synchronized samples are evaluated SCLK-first within the same cycle.

## Test plan
- Reset then write instruction 0x0003 with data 0xA5 -> wr_stb pulses once with wr_addr=3 and wr_data=0xA5; rd_addr=3 then gives rd_data=0xA5.
- Streaming write, instruction 0x6005, data 0x11, 0x22, 0x33 -> reg5=0x11, reg4=0x22, reg3=0x33, with three wr_stb pulses.
- After the previous test, read instruction 0xA005 (W=1, two bytes) -> sdo shifts out 0x11 then 0x22 MSB first. sdo_oe is high for 16 SCLK periods, then low, and remains low through further SCLK activity in DONE.
- Write instruction 0x0000 with data 0x7E, then csb raised after 5 data bits -> no wr_stb, reg0 unchanged, and the next transaction decodes correctly.
- Streaming write at address 0x0001 with data 0xC1, 0xC0, 0xFF -> reg1=0xC1 and reg0=0xC0. The third byte goes to address 0x1FFF, which is out of range: no third wr_stb and no register change. A read at 0x1FFF returns 0x00.
- rst_n pulsed low during instruction bit 8 -> all outputs return to their reset values at once and the register file clears. The following write of 0x0002 = 0x3C succeeds.
